spi_arb: RTL and testbench
==========================

SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 SHALL have clk, input, 1: sole clock, all logic on posedge.
REQ-002 SHALL have rst_n, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have req0 / req1, input, 1 each: level transaction request; held until matching done pulse.
REQ-004 SHALL have wt_data0 / wt_data1, input, 16 each: command word for requester 0 / 1; sampled at grant.
REQ-005 SHALL have gnt0 / gnt1, output, 1 each: owner indication, high from grant through DONE.
REQ-006 SHALL have done0 / done1, output, 1 each: one-cycle completion pulse to owner.
REQ-007 SHALL have rd_data, output, 16: response word from last completed transaction.
REQ-008 SHALL have err, output, 1: one-cycle pulse with done on timeout abort (macro only, else tied 0).
REQ-009 SHALL have mnrch_wrt, output, 1: start pulse to SPI monarch.
REQ-010 SHALL have mnrch_wt_data, output, 16: command word to SPI monarch.
REQ-011 SHALL have mnrch_done, input, 1: SPI monarch completion.
REQ-012 SHALL have mnrch_rd_data, input, 16: SPI monarch read data.

Function
REQ-013 SHALL implement FSM IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-014 IDLE: if any req sampled high, SHALL select owner, latch its wt_data into mnrch_wt_data, assert gnt of owner, go ISSUE.
REQ-015 Both req high in IDLE: SHALL grant requester not served last (round-robin); first grant after reset goes to req0.
REQ-016 ISSUE: mnrch_wrt SHALL be high exactly this one cycle; next state WAIT.
REQ-017 WAIT: on mnrch_done, SHALL latch mnrch_rd_data into rd_data, go DONE.
REQ-018 DONE: owner's done SHALL be high exactly this cycle; gnt drops and last-served pointer updates at exit; next state IDLE.
REQ-019 mnrch_wt_data SHALL stay stable from ISSUE until next grant.
REQ-020 mnrch_done in IDLE, ISSUE or DONE SHALL be ignored.
REQ-021 req of non-owner SHALL be ignored until IDLE; req of owner dropped mid-transaction SHALL NOT abort it.
REQ-022 Latency: req high at edge N -> mnrch_wrt high cycle N+1; mnrch_done at edge M -> done high cycle M+1.
REQ-023 Requester SHALL drop req on the edge ending its done cycle; a still-high req in IDLE is a new request.
REQ-024 gnt0 and gnt1 SHALL never be high together; done0/done1 never together.

Reset
REQ-025 On rst_n low at posedge: state IDLE; gnt*, done*, err, mnrch_wrt = 0; mnrch_wt_data, rd_data = 16'h0000; last-served = requester 1.
REQ-026 Reset mid-transaction SHALL abort silently: no done pulse; later stray mnrch_done ignored per REQ-020.

Configuration
REQ-027 Macro SPI_ARB_TIMEOUT_EN defined: WAIT SHALL count cycles (10-bit); at 1023 cycles without mnrch_done, go DONE with rd_data = 16'hFFFF and err pulsed with done.
REQ-028 Macro undefined: no counter; WAIT waits indefinitely; err constant 0.

Structure
REQ-029 Package spi_arb_pkg SHALL hold state enum, requester-id type, TIMEOUT_CYC = 1023, ABORT_DATA = 16'hFFFF.
REQ-030 Timeout counter SHALL be sub-module spi_arb_wdog (clear/enable/expire), instantiated only under SPI_ARB_TIMEOUT_EN.

Verification
REQ-031 req0 only, wt_data0 = 16'hA700, mnrch_done 40 cycles later with 16'h00C3 -> one mnrch_wrt, mnrch_wt_data = A700, done0 once, rd_data = 00C3.
REQ-032 req0 and req1 high in same IDLE cycle after reset -> req0 served first, then req1 (wt_data1 = 16'h0D02) without extra request.
REQ-033 Both held continuously for 4 transactions -> grants alternate 0,1,0,1; gnt never overlap.
REQ-034 Reset asserted in WAIT, mnrch_done 3 cycles later -> no done pulse, state IDLE, rd_data = 0000.
REQ-035 SPI_ARB_TIMEOUT_EN, mnrch_done never asserted -> done high plus err high 1024 cycles after ISSUE, rd_data = FFFF; without macro arbiter stays in WAIT.
REQ-036 mnrch_done pulsed while IDLE, no req -> no done, no state change.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI monarch arbiter.
// Optional timeout abort is enabled with SPI_ARB_TIMEOUT_EN.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_id_e;

    localparam int unsigned TIMEOUT_CYC = 1023;
    localparam int unsigned WDOG_W      = 10;
    localparam logic [15:0] ABORT_DATA  = 16'hFFFF;

    // Round-robin choice: on contention the requester not served last wins.
    function automatic req_id_e pick_owner(input logic r0, input logic r1, input req_id_e last);
        if (r0 && r1) begin
            return (last == REQ_0) ? REQ_1 : REQ_0;
        end else if (r0) begin
            return REQ_0;
        end else begin
            return REQ_1;
        end
    endfunction

endpackage

// File: rtl/spi_arb_if.sv
// Requester-side and SPI-monarch-side signals of the arbiter, bundled.
// slave = arbiter view, master = environment view.
interface spi_arb_if;

    logic        req0;
    logic        req1;
    logic [15:0] wt_data0;
    logic [15:0] wt_data1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [15:0] rd_data;
    logic        err;
    logic        mnrch_wrt;
    logic [15:0] mnrch_wt_data;
    logic        mnrch_done;
    logic [15:0] mnrch_rd_data;

    modport slave (
        input  req0, req1, wt_data0, wt_data1, mnrch_done, mnrch_rd_data,
        output gnt0, gnt1, done0, done1, rd_data, err, mnrch_wrt, mnrch_wt_data
    );

    modport master (
        output req0, req1, wt_data0, wt_data1, mnrch_done, mnrch_rd_data,
        input  gnt0, gnt1, done0, done1, rd_data, err, mnrch_wrt, mnrch_wt_data
    );

endinterface

// File: rtl/spi_arb_wdog.sv
// WAIT-state watchdog: counts enabled cycles and flags the last allowed one.
// Only built when SPI_ARB_TIMEOUT_EN is defined.
`ifdef SPI_ARB_TIMEOUT_EN
module spi_arb_wdog
    import spi_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [WDOG_W-1:0] LAST_CNT = WDOG_W'(TIMEOUT_CYC - 1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of earlier enabled cycles, so this fires on the 1023rd.
    assign expire_o = enable_i && (cnt_q == LAST_CNT);

endmodule
`endif

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI monarch between two requesters.
// Define SPI_ARB_TIMEOUT_EN to abort stalled transactions with err.
module spi_arb
    import spi_arb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    spi_arb_if.slave  bus
);

    state_e      state_q, state_d;
    req_id_e     owner_q, owner_d;
    req_id_e     last_q, last_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        wrt_q, wrt_d;
    logic [15:0] wt_data_q, wt_data_d;
    logic [15:0] rd_data_q, rd_data_d;

`ifdef SPI_ARB_TIMEOUT_EN
    logic err_q, err_d;
    logic wdog_expire;

    spi_arb_wdog u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_q != ST_WAIT),
        .enable_i (state_q == ST_WAIT),
        .expire_o (wdog_expire)
    );
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        wrt_d     = 1'b0;
        wt_data_d = wt_data_q;
        rd_data_d = rd_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d   = pick_owner(bus.req0, bus.req1, last_q);
                    wt_data_d = (owner_d == REQ_0) ? bus.wt_data0 : bus.wt_data1;
                    gnt0_d    = (owner_d == REQ_0);
                    gnt1_d    = (owner_d == REQ_1);
                    wrt_d     = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A real completion wins over a simultaneous timeout.
                if (bus.mnrch_done) begin
                    rd_data_d = bus.mnrch_rd_data;
                    done0_d   = (owner_q == REQ_0);
                    done1_d   = (owner_q == REQ_1);
                    state_d   = ST_DONE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (wdog_expire) begin
                    rd_data_d = ABORT_DATA;
                    done0_d   = (owner_q == REQ_0);
                    done1_d   = (owner_q == REQ_1);
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= REQ_0;
            last_q    <= REQ_1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            wrt_q     <= 1'b0;
            wt_data_q <= 16'h0000;
            rd_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            wrt_q     <= wrt_d;
            wt_data_q <= wt_data_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt0          = gnt0_q;
    assign bus.gnt1          = gnt1_q;
    assign bus.done0         = done0_q;
    assign bus.done1         = done1_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.mnrch_wrt     = wrt_q;
    assign bus.mnrch_wt_data = wt_data_q;

endmodule

// File: tb/tb_spi_arb.sv
// Randomized self-checking bench for spi_arb against a transaction-level model.
// Timeout expectations follow SPI_ARB_TIMEOUT_EN.
module tb_spi_arb;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    // Reference model state: who was served last and the last response word.
    int          lastServed;
    logic [15:0] lastRd;

    spi_arb_if bus ();

    spi_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Runs one full transaction starting at a negedge in IDLE and ending at the next IDLE negedge.
    task automatic applyStimulus(input bit r0, input bit r1, input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [15:0] rdat, input int delay, input bit wiggle);
        int          w;
        logic [15:0] wd;
        bit          sawDone;
        bit          sawWrt;
        w  = (r0 && r1) ? ((lastServed == 0) ? 1 : 0) : (r0 ? 0 : 1);
        wd = (w == 0) ? d0 : d1;
        bus.req0     = r0;
        bus.req1     = r1;
        bus.wt_data0 = d0;
        bus.wt_data1 = d1;
        @(negedge clk);
        checkOutput("gntOwner", (w == 0) ? bus.gnt0 : bus.gnt1, 1);
        checkOutput("gntOther", (w == 0) ? bus.gnt1 : bus.gnt0, 0);
        checkOutput("wrtIssue", bus.mnrch_wrt, 1);
        checkOutput("wtDataGrant", bus.mnrch_wt_data, wd);
        if (wiggle) begin
            bus.mnrch_done    = 1'b1;
            bus.mnrch_rd_data = 16'($urandom);
            bus.wt_data0      = 16'($urandom);
            bus.wt_data1      = 16'($urandom);
        end
        @(negedge clk);
        bus.mnrch_done = 1'b0;
        checkOutput("wrtOnce", bus.mnrch_wrt, 0);
        sawDone = 0;
        sawWrt  = 0;
        repeat (delay) begin
            sawDone |= (bus.done0 | bus.done1);
            sawWrt  |= bus.mnrch_wrt;
            if (wiggle) begin
                if (w == 0) bus.req1 = 1'($urandom);
                else        bus.req0 = 1'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    if (w == 0) bus.req0 = 1'b0;
                    else        bus.req1 = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.mnrch_done    = 1'b1;
        bus.mnrch_rd_data = rdat;
        @(negedge clk);
        bus.mnrch_done = 1'b0;
        checkOutput("noEarlyDone", sawDone, 0);
        checkOutput("noExtraWrt", sawWrt, 0);
        checkOutput("doneOwner", (w == 0) ? bus.done0 : bus.done1, 1);
        checkOutput("doneOther", (w == 0) ? bus.done1 : bus.done0, 0);
        checkOutput("gntHeld", (w == 0) ? {bus.gnt1, bus.gnt0} : {bus.gnt0, bus.gnt1}, 2'b01);
        checkOutput("rdData", bus.rd_data, rdat);
        checkOutput("wtStable", bus.mnrch_wt_data, wd);
        checkOutput("errNormal", bus.err, 0);
        if (w == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
        if (wiggle) begin
            bus.mnrch_done    = 1'b1;
            bus.mnrch_rd_data = ~rdat;
        end
        @(negedge clk);
        bus.mnrch_done = 1'b0;
        checkOutput("doneOnce", bus.done0 | bus.done1, 0);
        checkOutput("gntRelease", bus.gnt0 | bus.gnt1, 0);
        checkOutput("rdHold", bus.rd_data, rdat);
        lastServed = w;
        lastRd     = rdat;
    endtask

    initial begin
        int          n;
        bit          seen;
        bit          sawAny;
        int          pat;
        testsRun          = 0;
        testsFailed       = 0;
        lastServed        = 1;
        lastRd            = 16'h0000;
        rst_n             = 1'b0;
        bus.req0          = 1'b0;
        bus.req1          = 1'b0;
        bus.wt_data0      = 16'h0000;
        bus.wt_data1      = 16'h0000;
        bus.mnrch_done    = 1'b0;
        bus.mnrch_rd_data = 16'h0000;

        repeat (3) @(negedge clk);
        checkOutput("rstGnt", {bus.gnt0, bus.gnt1}, 0);
        checkOutput("rstDone", {bus.done0, bus.done1}, 0);
        checkOutput("rstWrt", bus.mnrch_wrt, 0);
        checkOutput("rstErr", bus.err, 0);
        checkOutput("rstWtData", bus.mnrch_wt_data, 16'h0000);
        checkOutput("rstRdData", bus.rd_data, 16'h0000);
        rst_n = 1'b1;

        // Contention straight after reset: req0 first, then the held req1.
        applyStimulus(1, 1, 16'h1234, 16'h0D02, 16'h5A5A, 5, 0);
        applyStimulus(0, 1, 16'h1234, 16'h0D02, 16'h6B6B, 5, 0);

        // Both held continuously: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 6), 0);
        end

        // Single requester, long monarch latency.
        applyStimulus(1, 0, 16'hA700, 16'h0000, 16'h00C3, 40, 0);

        // Stray completion while IDLE must be ignored.
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.mnrch_done    = 1'b1;
        bus.mnrch_rd_data = 16'hBEEF;
        @(negedge clk);
        bus.mnrch_done = 1'b0;
        sawAny = 0;
        repeat (4) begin
            sawAny |= (bus.done0 | bus.done1 | bus.gnt0 | bus.gnt1 | bus.mnrch_wrt);
            @(negedge clk);
        end
        checkOutput("idleStrayIgnored", sawAny, 0);
        checkOutput("idleStrayRd", bus.rd_data, lastRd);

        // Randomized traffic with ignored stray completions and req wiggling.
        for (int i = 0; i < 20; i++) begin
            pat = $urandom_range(1, 3);
            applyStimulus(pat[0], pat[1], 16'($urandom), 16'($urandom), 16'($urandom),
                          $urandom_range(0, 8), 1);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (lastRd == 16'h0000) begin
            applyStimulus(1, 0, 16'h1111, 16'h0000, 16'h4242, 2, 0);
        end

        // Reset while waiting on the monarch aborts silently.
        bus.req0     = 1'b1;
        bus.wt_data0 = 16'h7777;
        @(negedge clk);
        checkOutput("preRstGrant", bus.gnt0, 1);
        repeat (2) @(negedge clk);
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus.mnrch_done    = 1'b1;
        bus.mnrch_rd_data = 16'h9999;
        @(negedge clk);
        bus.mnrch_done = 1'b0;
        sawAny = 0;
        repeat (5) begin
            sawAny |= (bus.done0 | bus.done1 | bus.gnt0 | bus.gnt1 | bus.mnrch_wrt);
            @(negedge clk);
        end
        checkOutput("rstAbortQuiet", sawAny, 0);
        checkOutput("rstAbortRd", bus.rd_data, 16'h0000);
        checkOutput("rstAbortWt", bus.mnrch_wt_data, 16'h0000);
        lastServed = 1;
        lastRd     = 16'h0000;
        applyStimulus(1, 1, 16'h2468, 16'h1357, 16'h0F0F, 3, 0);

        // Monarch never completes.
        bus.req1     = 1'b1;
        bus.wt_data1 = 16'hC0DE;
        @(negedge clk);
        checkOutput("toIssue", bus.mnrch_wrt, 1);
        n    = 0;
        seen = 0;
        while (n < 1100 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.done1 || bus.done0) seen = 1;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        checkOutput("toSeen", seen, 1);
        checkOutput("toCycles", n, 1024);
        checkOutput("toErr", bus.err, 1);
        checkOutput("toDone1", bus.done1, 1);
        checkOutput("toRd", bus.rd_data, 16'hFFFF);
        bus.req1 = 1'b0;
        @(negedge clk);
        checkOutput("toErrPulse", bus.err, 0);
        checkOutput("toRelease", bus.gnt1, 0);
`else
        checkOutput("stuckNoDone", seen, 0);
        checkOutput("stuckGnt", bus.gnt1, 1);
        checkOutput("stuckErr", bus.err, 0);
        bus.mnrch_done    = 1'b1;
        bus.mnrch_rd_data = 16'h3C3C;
        @(negedge clk);
        bus.mnrch_done = 1'b0;
        checkOutput("lateDone", bus.done1, 1);
        checkOutput("lateRd", bus.rd_data, 16'h3C3C);
        bus.req1 = 1'b0;
        @(negedge clk);
        checkOutput("lateRelease", bus.gnt1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
